// File: rtl/i2c_reader_pkg.sv
// Shared definitions for the I2C register reader: FSM state encoding, error
// codes and small state-classification helpers.
package i2c_reader_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        STOP_WR,
        READ_HI,
        READ_LO,
        STOP_RD,
        DONE,
        ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    // States in which the controller is actively moving a byte; only these
    // request a transfer and only these react to ack/nack events.
    function automatic logic is_byte_state(input state_t s);
        return (s == ADDR_HI) || (s == ADDR_LO) || (s == READ_HI) || (s == READ_LO);
    endfunction

endpackage

// File: rtl/i2c_event_sync.sv
// Brings the controller status lines (ack, nack, idle) from the slow I2C
// clock domain into clk through a 2-flop synchronizer and derives one-cycle
// rising-edge events for ack and nack.
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   i_ack/i_nack      raw controller byte status
//   i_idle            raw controller idle flag
//   o_ack_evt         one-cycle pulse on a synchronized ack rising edge
//   o_nack_evt        one-cycle pulse on a synchronized nack rising edge
//   o_idle            synchronized idle level
module i2c_event_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_ack,
    input  logic i_nack,
    input  logic i_idle,
    output logic o_ack_evt,
    output logic o_nack_evt,
    output logic o_idle
);

    // Bit order in all vectors: {idle, nack, ack}.
    logic [2:0] r_meta;
    logic [2:0] r_sync;
    logic [1:0] r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= {i_idle, i_nack, i_ack};
            r_sync <= r_meta;
            r_prev <= r_sync[1:0];
        end
    end

    assign o_ack_evt  = r_sync[0] & ~r_prev[0];
    assign o_nack_evt = r_sync[1] & ~r_prev[1];
    assign o_idle     = r_sync[2];

endmodule

// File: rtl/i2c_register_reader.sv
// Sequences a byte-level I2C controller to read consecutive 16-bit registers
// from a sensor: write the 16-bit start address, stop, then read 2N bytes and
// return them as a stream of {hi,lo} words with a valid/ready handshake.
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_reg_addr          first register address
//   req_word_count        number of 16-bit words to read (0 = no bus activity)
//   rd_data/rd_valid      assembled word, held until rd_ready
//   rd_ready              consumer accepts the held word
//   done / error          one-cycle completion / abort pulses
//   error_code            cause of the last abort, cleared on the next request
//   i2c_*                 controller interface; every controller input is owned here
module i2c_register_reader
    import i2c_reader_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR    = 7'h33,
    parameter int         COUNT_W        = 10,
    parameter int         TIMEOUT_CYCLES = 24000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [15:0]        req_reg_addr,
    input  logic [COUNT_W-1:0] req_word_count,
    output logic [15:0]        rd_data,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic               done,
    output logic               error,
    output logic [1:0]         error_code,
    output logic [6:0]         i2c_address,
    output logic               i2c_read_write,
    output logic [7:0]         i2c_transmit_data,
    output logic               i2c_enable_transfer,
    input  logic               i2c_ack,
    input  logic               i2c_nack,
    input  logic               i2c_idle,
    input  logic [7:0]         i2c_received_data
);

    localparam int              TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         w_err_code;
    logic               w_enable;
    logic [7:0]         w_tx;

    logic [15:0]        r_addr;
    logic [COUNT_W-1:0] r_wcnt;
    logic [7:0]         r_hi;
    logic [15:0]        r_rd_data;
    logic               r_rd_valid;
    logic               r_error;
    logic [1:0]         r_error_code;
    logic               r_rw;
    logic [TMO_W-1:0]   r_tmo;

    logic               w_ack_evt;
    logic               w_nack_evt;
    logic               w_idle;
    logic               w_timeout;
    logic               w_accept;
    logic               w_enter_error;

    i2c_event_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .i_ack      (i2c_ack),
        .i_nack     (i2c_nack),
        .i_idle     (i2c_idle),
        .o_ack_evt  (w_ack_evt),
        .o_nack_evt (w_nack_evt),
        .o_idle     (w_idle)
    );

    assign w_timeout     = (r_tmo == TMO_MAX);
    assign w_accept      = (r_state == IDLE) && req_valid;
    assign w_enter_error = (w_next == ERROR) && (r_state != ERROR);

    // NOTE: state register uses non-blocking assignment so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_next     = r_state;
        w_err_code = ERR_NONE;
        w_enable   = is_byte_state(r_state);
        w_tx       = (r_state == ADDR_HI) ? r_addr[15:8] : r_addr[7:0];

        // nack is checked before ack in each byte state so it wins a tie;
        // ack before timeout because an ack also restarts the timeout.
        case (r_state)
            IDLE: begin
                if (req_valid) w_next = (req_word_count == '0) ? DONE : ADDR_HI;
            end
            ADDR_HI, ADDR_LO, READ_HI: begin
                if (w_nack_evt) begin
                    w_next     = ERROR;
                    w_err_code = ERR_NACK;
                end else if (w_ack_evt) begin
                    w_next = (r_state == ADDR_HI) ? ADDR_LO :
                             (r_state == ADDR_LO) ? STOP_WR : READ_LO;
                end else if (w_timeout) begin
                    w_next     = ERROR;
                    w_err_code = ERR_TIMEOUT;
                end
            end
            READ_LO: begin
                if (w_nack_evt) begin
                    w_next     = ERROR;
                    w_err_code = ERR_NACK;
                end else if (w_ack_evt) begin
                    // A word still waiting (and not taken this cycle) would be lost.
                    if (r_rd_valid && !rd_ready) begin
                        w_next     = ERROR;
                        w_err_code = ERR_OVERRUN;
                    end else begin
                        w_next = (r_wcnt == COUNT_W'(1)) ? STOP_RD : READ_HI;
                    end
                end else if (w_timeout) begin
                    w_next     = ERROR;
                    w_err_code = ERR_TIMEOUT;
                end
            end
            STOP_WR, STOP_RD: begin
                if (w_idle) begin
                    w_next = (r_state == STOP_WR) ? READ_HI : DONE;
                end else if (w_timeout) begin
                    w_next     = ERROR;
                    w_err_code = ERR_TIMEOUT;
                end
            end
            DONE:    w_next = IDLE;
            ERROR:   if (w_idle) w_next = IDLE;
            default: w_next = IDLE;
        endcase

        // Drop the transfer request in the cycle the FSM commits to leaving a
        // byte phase, so the controller never starts an unwanted extra byte.
        if (!is_byte_state(w_next)) w_enable = 1'b0;
    end

    // NOTE: all datapath registers have an asynchronous reset so every output
    // is defined the moment reset is asserted, not one clock later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr       <= '0;
            r_wcnt       <= '0;
            r_hi         <= '0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_error      <= 1'b0;
            r_error_code <= ERR_NONE;
            r_rw         <= 1'b0;
            r_tmo        <= '0;
        end else begin
            if (r_rd_valid && rd_ready) r_rd_valid <= 1'b0;

            r_error <= w_enter_error;
            if (w_enter_error) r_error_code <= w_err_code;

            if (w_accept) begin
                r_addr       <= req_reg_addr;
                r_wcnt       <= req_word_count;
                r_error_code <= ERR_NONE;
                r_rw         <= 1'b0;
            end

            if (r_state == STOP_WR && w_next == READ_HI) r_rw <= 1'b1;

            if (r_state == READ_HI && w_next == READ_LO) r_hi <= i2c_received_data;

            // On overrun the held word is kept so the consumer still gets it.
            if (r_state == READ_LO && w_ack_evt && w_next != ERROR) begin
                r_rd_data  <= {r_hi, i2c_received_data};
                r_rd_valid <= 1'b1;
                r_wcnt     <= r_wcnt - COUNT_W'(1);
            end

            if ((w_next != r_state) || w_ack_evt) r_tmo <= '0;
            else if (!w_timeout)                  r_tmo <= r_tmo + TMO_W'(1);
        end
    end

    assign req_ready           = (r_state == IDLE);
    assign done                = (r_state == DONE);
    assign error               = r_error;
    assign error_code          = r_error_code;
    assign rd_data             = r_rd_data;
    assign rd_valid            = r_rd_valid;
    assign i2c_address         = DEVICE_ADDR;
    assign i2c_read_write      = r_rw;
    assign i2c_transmit_data   = w_tx;
    assign i2c_enable_transfer = w_enable;

endmodule

// File: tb/tb_i2c_register_reader.sv
// Self-checking bench for i2c_register_reader. A behavioural model of the
// byte-level controller answers each byte with an ack about 12 clocks after
// it starts and raises idle 8 clocks after the transfer request drops.
// Expected words go into a scoreboard queue when a request is issued and are
// compared as the consumer handshake takes them.
module tb_i2c_register_reader;

    localparam int COUNT_W = 10;
    localparam int TMO     = 400;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [15:0]        req_reg_addr = '0;
    logic [COUNT_W-1:0] req_word_count = '0;
    logic [15:0]        rd_data;
    logic               rd_valid;
    logic               rd_ready = 1'b1;
    logic               done;
    logic               error;
    logic [1:0]         error_code;
    logic [6:0]         i2c_address;
    logic               i2c_read_write;
    logic [7:0]         i2c_transmit_data;
    logic               i2c_enable_transfer;
    logic               i2c_ack;
    logic               i2c_nack;
    logic               i2c_idle;
    logic [7:0]         i2c_received_data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    i2c_register_reader #(
        .DEVICE_ADDR    (7'h33),
        .COUNT_W        (COUNT_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_reg_addr        (req_reg_addr),
        .req_word_count      (req_word_count),
        .rd_data             (rd_data),
        .rd_valid            (rd_valid),
        .rd_ready            (rd_ready),
        .done                (done),
        .error               (error),
        .error_code          (error_code),
        .i2c_address         (i2c_address),
        .i2c_read_write      (i2c_read_write),
        .i2c_transmit_data   (i2c_transmit_data),
        .i2c_enable_transfer (i2c_enable_transfer),
        .i2c_ack             (i2c_ack),
        .i2c_nack            (i2c_nack),
        .i2c_idle            (i2c_idle),
        .i2c_received_data   (i2c_received_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- controller model ----------------
    typedef enum {M_IDLE, M_BYTE, M_PULSE, M_GAP, M_STOP, M_HANG} mph_t;
    mph_t       m_ph;
    int         m_cnt;
    int         m_nb;
    logic       m_rw;
    logic [7:0] byte_q[$];
    logic [7:0] tx_log[$];
    logic       rw_log[$];
    int         rd_bytes = 0;
    int         nack_wr_byte = -1;
    bit         mute_rd = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            i2c_ack  <= 1'b0;
            i2c_nack <= 1'b0;
            i2c_idle <= 1'b1;
            m_ph     <= M_IDLE;
            m_cnt    <= 0;
            m_nb     <= 0;
            m_rw     <= 1'b0;
        end else begin
            case (m_ph)
                M_IDLE: if (i2c_enable_transfer) begin
                    i2c_idle <= 1'b0;
                    m_rw     <= i2c_read_write;
                    rw_log.push_back(i2c_read_write);
                    m_nb     <= 0;
                    m_cnt    <= 0;
                    m_ph     <= M_BYTE;
                end
                M_BYTE: begin
                    if (m_rw && mute_rd) begin
                        m_ph <= M_HANG;
                    end else if (m_cnt == 11) begin
                        m_cnt <= 0;
                        m_ph  <= M_PULSE;
                        if (!m_rw && m_nb == nack_wr_byte) begin
                            i2c_nack <= 1'b1;
                        end else begin
                            i2c_ack <= 1'b1;
                            if (m_rw) begin
                                i2c_received_data <= (byte_q.size() > 0) ? byte_q.pop_front() : 8'hEE;
                                rd_bytes <= rd_bytes + 1;
                            end else begin
                                tx_log.push_back(i2c_transmit_data);
                            end
                        end
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end
                M_PULSE: if (m_cnt == 2) begin
                    i2c_ack  <= 1'b0;
                    i2c_nack <= 1'b0;
                    m_cnt    <= 0;
                    m_nb     <= m_nb + 1;
                    m_ph     <= M_GAP;
                end else m_cnt <= m_cnt + 1;
                M_GAP: if (m_cnt == 2) begin
                    m_cnt <= 0;
                    m_ph  <= i2c_enable_transfer ? M_BYTE : M_STOP;
                end else m_cnt <= m_cnt + 1;
                M_STOP: if (m_cnt == 7) begin
                    i2c_idle <= 1'b1;
                    m_cnt    <= 0;
                    m_ph     <= M_IDLE;
                end else m_cnt <= m_cnt + 1;
                M_HANG: if (!i2c_enable_transfer) begin
                    m_cnt <= 0;
                    m_ph  <= M_STOP;
                end
                default: m_ph <= M_IDLE;
            endcase
        end
    end

    // ---------------- monitors and scoreboard ----------------
    logic [15:0] exp_q[$];
    int done_cnt = 0;
    int err_cnt  = 0;
    int en_cycles = 0;
    int rv_cycles = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (done)                done_cnt++;
            if (error)               err_cnt++;
            if (i2c_enable_transfer) en_cycles++;
            if (rd_valid)            rv_cycles++;
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) check("rd_unexpected_word", exp_q.size(), 1);
                else                   check("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_back", req_ready, 1);
    endtask

    task automatic do_req(input logic [15:0] addr, input int cnt);
        wait_ready();
        @(negedge clk);
        req_valid      = 1'b1;
        req_reg_addr   = addr;
        req_word_count = COUNT_W'(cnt);
        @(negedge clk);
        req_valid      = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int d0 = done_cnt;
        int e0 = err_cnt;
        int n  = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("request_ended_in_budget", (done_cnt != d0) || (err_cnt != e0), 1);
    endtask

    task automatic clear_logs();
        tx_log.delete();
        rw_log.delete();
    endtask

    initial begin
        int d0, e0, en0, rv0, rb0, n;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_enable", i2c_enable_transfer, 0);
        check("rst_rw", i2c_read_write, 0);
        check("rst_error_code", error_code, 0);
        check("rst_rd_data", rd_data, 0);
        check("i2c_address", i2c_address, 7'h33);

        // 1: single word
        clear_logs();
        d0 = done_cnt; e0 = err_cnt;
        byte_q = '{8'h01, 8'h23};
        exp_q.push_back(16'h0123);
        do_req(16'h2407, 1);
        wait_end(600);
        @(negedge clk);
        check("t1_done_pulses", done_cnt - d0, 1);
        check("t1_error_pulses", err_cnt - e0, 0);
        check("t1_tx_count", tx_log.size(), 2);
        if (tx_log.size() == 2) begin
            check("t1_tx0", tx_log[0], 8'h24);
            check("t1_tx1", tx_log[1], 8'h07);
        end
        check("t1_phases", rw_log.size(), 2);
        if (rw_log.size() == 2) begin
            check("t1_rw_write", rw_log[0], 0);
            check("t1_rw_read", rw_log[1], 1);
        end
        check("t1_error_code", error_code, 0);
        check("t1_enable_idle", i2c_enable_transfer, 0);

        // 2: three words streamed
        clear_logs();
        d0 = done_cnt; rb0 = rd_bytes;
        byte_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        exp_q.push_back(16'hA0A1);
        exp_q.push_back(16'hA2A3);
        exp_q.push_back(16'hA4A5);
        do_req(16'h0400, 3);
        wait_end(1200);
        @(negedge clk);
        check("t2_done_pulses", done_cnt - d0, 1);
        check("t2_read_bytes", rd_bytes - rb0, 6);
        check("t2_read_phases", rw_log.size(), 2);
        check("t2_words_left", exp_q.size(), 0);

        // 3: nack on the low address byte
        clear_logs();
        e0 = err_cnt; rv0 = rv_cycles;
        nack_wr_byte = 1;
        do_req(16'h1234, 1);
        wait_end(600);
        @(negedge clk);
        check("t3_error_pulses", err_cnt - e0, 1);
        check("t3_error_code", error_code, 2'b01);
        check("t3_enable_low", i2c_enable_transfer, 0);
        check("t3_no_rd_valid", rv_cycles - rv0, 0);
        check("t3_busy_until_idle", req_ready, 0);
        nack_wr_byte = -1;
        wait_ready();

        // 4: consumer stalls, second word overruns
        clear_logs();
        rd_ready = 1'b0;
        e0 = err_cnt;
        byte_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        exp_q.push_back(16'hB0B1);
        do_req(16'h0500, 2);
        wait_end(1200);
        @(negedge clk);
        check("t4_error_pulses", err_cnt - e0, 1);
        check("t4_error_code", error_code, 2'b11);
        check("t4_word_held", rd_valid, 1);
        rd_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("t4_words_left", exp_q.size(), 0);
        wait_ready();

        // 5: no ack in READ_HI, then a zero-length request
        clear_logs();
        mute_rd = 1'b1;
        do_req(16'h0600, 1);
        wait_end(TMO + 600);
        @(negedge clk);
        check("t5_error_code", error_code, 2'b10);
        mute_rd = 1'b0;
        wait_ready();
        en0 = en_cycles; d0 = done_cnt;
        @(negedge clk);
        req_valid      = 1'b1;
        req_reg_addr   = 16'h0700;
        req_word_count = '0;
        @(negedge clk);
        req_valid      = 1'b0;
        check("t5_zero_done_next", done, 1);
        check("t5_code_cleared", error_code, 0);
        repeat (20) @(negedge clk);
        check("t5_zero_no_enable", en_cycles - en0, 0);
        check("t5_zero_one_done", done_cnt - d0, 1);

        // 6: reset during READ_LO
        clear_logs();
        rb0 = rd_bytes;
        byte_q = '{8'hC0, 8'hC1};
        do_req(16'h0800, 1);
        n = 0;
        while (rd_bytes == rb0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("t6_hi_byte_seen", rd_bytes - rb0, 1);
        repeat (6) @(negedge clk);
        check("t6_pre_enable", i2c_enable_transfer, 1);
        check("t6_pre_rw", i2c_read_write, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_enable", i2c_enable_transfer, 0);
        check("t6_rst_rw", i2c_read_write, 0);
        check("t6_rst_req_ready", req_ready, 1);
        check("t6_rst_rd_valid", rd_valid, 0);
        check("t6_rst_rd_data", rd_data, 0);
        check("t6_rst_done_error", {done, error}, 0);
        check("t6_rst_error_code", error_code, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        byte_q.delete();
        clear_logs();
        d0 = done_cnt;
        byte_q = '{8'hD0, 8'hD1};
        exp_q.push_back(16'hD0D1);
        do_req(16'h0900, 1);
        wait_end(600);
        @(negedge clk);
        check("t6_after_done", done_cnt - d0, 1);
        check("t6_after_tx_count", tx_log.size(), 2);
        check("t6_words_left", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
